fifo_axis_accel_pipeline: RTL and testbench

Single-clock ingest pipeline with three stages. A synchronous write-side FIFO buffers 32-bit words. A FIFO-to-AXI-Stream bridge drains the FIFO, gated by a host read enable, and drives an internal AXIS master. A small streaming accelerator consumes the stream, emits one transformed result per beat and keeps a running sum and beat count.

---
 rtl/fifo_axis_accel_pipeline.sv | 160 ++++++++++++++++
 tb/tb_fifo_axis_accel_pipeline.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_accel_pipeline.sv
// Single-clock ingest pipeline: write-side FIFO -> FIFO-to-AXIS bridge -> streaming accelerator.
// The bridge pops at most one word at a time. A popped word spends one cycle on the FIFO
// read register and is then loaded onto the internal stream.
// The accelerator adds a constant to each accepted beat, keeps a running sum and a beat count,
// and stalls tready for a fixed number of cycles after each beat.
//
// Accelerator FSM
//   state      | meaning
//   ACC_READY  | tready high, waiting for a beat
//   ACC_BUSY   | tready low, busy down-counter running to terminal count 0
module fifo_axis_accel_pipeline #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int ADD_CONST   = 1,
    parameter int BUSY_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_WIDTH-1:0]    axis_tdata,
    output logic                     axis_tvalid,
    output logic                     axis_tready,
    output logic [DATA_WIDTH-1:0]    res_data,
    output logic                     res_valid,
    output logic [DATA_WIDTH-1:0]    acc_sum,
    output logic [15:0]              beat_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int BCW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [BCW-1:0] BUSY_LOAD = BCW'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);

    typedef enum logic {
        ACC_READY = 1'b0,
        ACC_BUSY  = 1'b1
    } acc_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  pop_pending;
    logic                  push;
    logic                  pop;
    logic                  handshake;

    acc_state_t            acc_state;
    acc_state_t            acc_state_nxt;
    logic [BCW-1:0]        busy_cnt;
    logic [BCW-1:0]        busy_cnt_nxt;

    assign full        = (level == LW'(DEPTH));
    assign empty       = (level == '0);
    assign axis_tready = (acc_state == ACC_READY);
    assign handshake   = axis_tvalid & axis_tready;

    // Only one word may be between the FIFO and the stream register at any time.
    assign pop  = rd_en & ~empty & ~pop_pending & (~axis_tvalid | handshake);
    assign push = wr_en & (~full | pop);

    // Storage array; contents are meaningless after reset since the pointers restart.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy, registered read and stream output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            fifo_dout   <= '0;
            pop_pending <= 1'b0;
            axis_tdata  <= '0;
            axis_tvalid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                fifo_dout <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            pop_pending <= pop;
            if (pop_pending) begin
                axis_tdata  <= fifo_dout;
                axis_tvalid <= 1'b1;
            end else if (handshake) begin
                axis_tvalid <= 1'b0;
            end
        end
    end

    // Accelerator datapath: result, running sum and beat count update on each accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_data   <= '0;
            res_valid  <= 1'b0;
            acc_sum    <= '0;
            beat_count <= '0;
        end else begin
            res_valid <= handshake;
            if (handshake) begin
                res_data   <= axis_tdata + DATA_WIDTH'(ADD_CONST);
                acc_sum    <= acc_sum + axis_tdata;
                beat_count <= beat_count + 16'd1;
            end
        end
    end

    // Accelerator state register and busy down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_state <= ACC_READY;
            busy_cnt  <= '0;
        end else begin
            acc_state <= acc_state_nxt;
            busy_cnt  <= busy_cnt_nxt;
        end
    end

    // Next-state logic: a beat starts the busy window, terminal count 0 ends it.
    always_comb begin
        acc_state_nxt = acc_state;
        busy_cnt_nxt  = busy_cnt;
        case (acc_state)
            ACC_READY: begin
                if (handshake && (BUSY_CYCLES > 0)) begin
                    acc_state_nxt = ACC_BUSY;
                    busy_cnt_nxt  = BUSY_LOAD;
                end
            end
            ACC_BUSY: begin
                if (busy_cnt == '0) begin
                    acc_state_nxt = ACC_READY;
                end else begin
                    busy_cnt_nxt = busy_cnt - 1'b1;
                end
            end
            default: begin
                acc_state_nxt = ACC_READY;
                busy_cnt_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_axis_accel_pipeline.sv
// Scoreboard bench for fifo_axis_accel_pipeline (DEPTH=16, ADD_CONST=1, BUSY_CYCLES=3).
// Stimulus pushes expected results as words are written; a negedge monitor pops and compares
// every res_valid pulse, and also checks AXIS hold behaviour and the tready busy window.
module tb_fifo_axis_accel_pipeline;

    localparam int DW   = 32;
    localparam int DEP  = 16;
    localparam int BUSY = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          full;
    logic          empty;
    logic [4:0]    level;
    logic [DW-1:0] axis_tdata;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic [DW-1:0] acc_sum;
    logic [15:0]   beat_count;

    fifo_axis_accel_pipeline #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .ADD_CONST  (1),
        .BUSY_CYCLES(BUSY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .axis_tdata (axis_tdata),
        .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .acc_sum    (acc_sum),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_sum = '0;
    int            exp_beats = 0;
    int            received = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_tdata = '0;
    logic          in_busy = 1'b0;
    int            low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Called at posedge+1; the write lands on the next edge.
    task automatic wr(input logic [DW-1:0] d, input bit accept);
        din   = d;
        wr_en = 1'b1;
        if (accept) begin
            exp_q.push_back(d + 32'd1);
            exp_sum   = exp_sum + d;
            exp_beats = exp_beats + 1;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && empty && !axis_tvalid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) timeout_fail(name);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares results against the scoreboard and checks stream protocol timing.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            in_busy    = 1'b0;
            low_cnt    = 0;
        end else begin
            if (res_valid) begin
                received++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_res: got 0x%0h expected no result", res_data);
                end else begin
                    check("res_data", res_data, exp_q.pop_front());
                end
            end
            if (prev_stall) begin
                check("hold_tvalid", 32'(axis_tvalid), 32'd1);
                check("hold_tdata", axis_tdata, prev_tdata);
            end
            if (in_busy) begin
                if (!axis_tready) begin
                    low_cnt++;
                end else begin
                    check("busy_len", 32'(low_cnt), 32'(BUSY));
                    in_busy = 1'b0;
                end
            end
            if (axis_tvalid && axis_tready) begin
                in_busy = 1'b1;
                low_cnt = 0;
            end
            prev_stall = axis_tvalid && !axis_tready;
            prev_tdata = axis_tdata;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rcv_base;
        bit found;

        // Reset held for two cycles, then released.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_tvalid", 32'(axis_tvalid), 32'd0);
        check("rst_tready", 32'(axis_tready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_acc_sum", acc_sum, 32'd0);
        check("rst_beats", 32'(beat_count), 32'd0);

        // Four words buffered with drain disabled, then drained.
        wr(32'hDD, 1);
        wr(32'hDE, 1);
        wr(32'hDF, 1);
        wr(32'hE0, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hold_level", 32'(level), 32'd4);
        check("hold_no_tvalid", 32'(axis_tvalid), 32'd0);
        rd_en = 1'b1;
        wait_drain("drain4", 200);
        check("sum4", acc_sum, 32'h37A);
        check("beats4", 32'(beat_count), 32'd4);
        check("empty4", 32'(empty), 32'd1);

        // Fill to full, drop an overflow write, then write with a simultaneous pop.
        rd_en = 1'b0;
        for (int i = 0; i < DEP; i++) wr(32'h100 + 32'(i), 1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd16);
        wr(32'hBAD, 0);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
        rd_en = 1'b1;
        wr(32'h200, 1);
        check("wr_pop_level", 32'(level), 32'd16);
        wait_drain("drain_full", 600);
        check("sum_full", acc_sum, exp_sum);
        check("beats_full", 32'(beat_count), 32'(exp_beats[15:0]));

        // Drop rd_en right after the second pop; in-flight word must still arrive.
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) wr(32'hA0 + 32'(i), 1);
        rcv_base = received;
        rd_en = 1'b1;
        n = 0;
        while (level != 5'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) timeout_fail("second_pop");
        rd_en = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("pause_level", 32'(level), 32'd4);
        check("pause_delivered", 32'(received - rcv_base), 32'd2);
        check("pause_tvalid", 32'(axis_tvalid), 32'd0);
        rd_en = 1'b1;
        wait_drain("drain_pause", 300);
        check("sum_pause", acc_sum, exp_sum);
        check("beats_pause", 32'(beat_count), 32'(exp_beats[15:0]));

        // Reset while a beat is pending and three words remain queued.
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) wr(32'h300 + 32'(i), 1);
        rd_en = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (axis_tvalid && level == 5'd3) found = 1'b1;
            n++;
        end
        if (!found) timeout_fail("mid_reset_setup");
        #2;
        rst = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        exp_sum = '0;
        exp_beats = 0;
        #1;
        check("mr_tvalid", 32'(axis_tvalid), 32'd0);
        check("mr_level", 32'(level), 32'd0);
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_res_valid", 32'(res_valid), 32'd0);
        check("mr_acc_sum", acc_sum, 32'd0);
        check("mr_beats", 32'(beat_count), 32'd0);
        check("mr_tready", 32'(axis_tready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rd_en = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_tvalid", 32'(axis_tvalid), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_beats", 32'(beat_count), 32'd0);

        // Fresh traffic after reset.
        wr(32'h10, 1);
        wr(32'h20, 1);
        wait_drain("drain_post", 200);
        check("sum_post", acc_sum, 32'h30);
        check("beats_post", 32'(beat_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
